// File: rtl/smpc_pad_poll.sv
// Host-side poller for one Saturn control port in TH/TR handshake mode.
// Probes for a digital pad, walks four TH/TR phases and latches the 16-bit button word.
module smpc_pad_poll #(
    parameter int SETTLE = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE,
    input  logic        START,
    output logic        BUSY,
    output logic        DONE,
    output logic        PRESENT,
    output logic [15:0] BUTTONS,
    output logic [6:0]  DDR,
    output logic [6:0]  PDRO,
    input  logic [6:0]  PDRI
);

    // state   | meaning
    // S_IDLE  | port released, waiting for START
    // S_PROBE | port released, check pad pulls PDRI[1:0] low
    // S_PH0   | TH=0 TR=0, capture B[7:4]
    // S_PH1   | TH=0 TR=1, capture B[15:12]
    // S_PH2   | TH=1 TR=0, capture B[11:8]
    // S_PH3   | TH=1 TR=1, capture B[3] and pad ID
    // S_FIN   | result visible, DONE pulse on the CE tick
    typedef enum logic [2:0] {
        S_IDLE, S_PROBE, S_PH0, S_PH1, S_PH2, S_PH3, S_FIN
    } state_t;

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [11:0]    scr, scr_nxt;
    logic [15:0]    buttons_q, buttons_nxt;
    logic           present_q, present_nxt;
    logic           tc;
    logic           unused_pdri;

    assign unused_pdri = ^PDRI[6:4];
    assign tc = (cnt == CW'(SETTLE - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            cnt       <= '0;
            scr       <= '1;
            buttons_q <= 16'hFFFF;
            present_q <= 1'b0;
        end else if (CE) begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            scr       <= scr_nxt;
            buttons_q <= buttons_nxt;
            present_q <= present_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        scr_nxt     = scr;
        buttons_nxt = buttons_q;
        present_nxt = present_q;

        if (state inside {S_PROBE, S_PH0, S_PH1, S_PH2, S_PH3}) begin
            cnt_nxt = tc ? '0 : cnt + 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (START) begin
                    state_nxt = S_PROBE;
                    cnt_nxt   = '0;
                end
            end
            S_PROBE: begin
                if (tc) begin
                    if (PDRI[1:0] == 2'b00) begin
                        state_nxt = S_PH0;
                    end else begin
                        state_nxt   = S_FIN;
                        buttons_nxt = 16'hFFFF;
                        present_nxt = 1'b0;
                    end
                end
            end
            S_PH0: begin
                if (tc) begin
                    scr_nxt[3:0] = PDRI[3:0];
                    state_nxt    = S_PH1;
                end
            end
            S_PH1: begin
                if (tc) begin
                    scr_nxt[11:8] = PDRI[3:0];
                    state_nxt     = S_PH2;
                end
            end
            S_PH2: begin
                if (tc) begin
                    scr_nxt[7:4] = PDRI[3:0];
                    state_nxt    = S_PH3;
                end
            end
            S_PH3: begin
                // Result is committed on entry to FIN so it is valid alongside DONE.
                if (tc) begin
                    state_nxt = S_FIN;
                    if (PDRI[2:0] == 3'b100) begin
                        buttons_nxt = {scr[11:8], scr[7:4], scr[3:0], PDRI[3], 3'b111};
                        present_nxt = 1'b1;
                    end else begin
                        buttons_nxt = 16'hFFFF;
                        present_nxt = 1'b0;
                    end
                end
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        DDR  = 7'h00;
        PDRO = 7'h7F;
        BUSY = 1'b0;
        DONE = 1'b0;
        case (state)
            S_PROBE: BUSY = 1'b1;
            S_PH0: begin
                BUSY = 1'b1;
                DDR  = 7'h60;
                PDRO = {2'b00, 5'h1F};
            end
            S_PH1: begin
                BUSY = 1'b1;
                DDR  = 7'h60;
                PDRO = {2'b01, 5'h1F};
            end
            S_PH2: begin
                BUSY = 1'b1;
                DDR  = 7'h60;
                PDRO = {2'b10, 5'h1F};
            end
            S_PH3: begin
                BUSY = 1'b1;
                DDR  = 7'h60;
                PDRO = {2'b11, 5'h1F};
            end
            S_FIN:   DONE = CE;
            default: ;
        endcase
    end

    assign BUTTONS = buttons_q;
    assign PRESENT = present_q;

endmodule

// File: tb/tb_smpc_pad_poll.sv
// Directed bench for smpc_pad_poll with a behavioural Saturn pad on the port.
module tb_smpc_pad_poll;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CE = 1'b1;
    logic        START = 1'b0;
    logic        BUSY, DONE, PRESENT;
    logic [15:0] BUTTONS;
    logic [6:0]  DDR, PDRO, PDRI;

    int checks = 0;
    int failures = 0;

    logic [15:0] joy = 16'h1234;
    int          pad_mode = 0;   // 0 pad, 1 unconnected, 2 pad with wrong ID
    int          ce_div = 1;
    int          ce_ph = 0;

    int          r_ticks;
    bit          r_done, r_saw60, r_early, r_ce_at_done;
    logic [15:0] r_buttons;
    logic        r_present;
    logic [13:0] r_log[$];
    int          r_len[$];

    smpc_pad_poll #(.SETTLE(8)) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .START(START),
        .BUSY(BUSY), .DONE(DONE), .PRESENT(PRESENT), .BUTTONS(BUTTONS),
        .DDR(DDR), .PDRO(PDRO), .PDRI(PDRI)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        #1;
        ce_ph = (ce_ph + 1) % ce_div;
        CE = (ce_ph == 0);
    end

    always_comb begin
        PDRI = 7'h7F;
        if (pad_mode != 1) begin
            if (DDR == 7'h60) begin
                case (PDRO[6:5])
                    2'b00:   PDRI = {PDRO[6:5], 1'b1, joy[7:4]};
                    2'b01:   PDRI = {PDRO[6:5], 1'b1, joy[15:12]};
                    2'b10:   PDRI = {PDRO[6:5], 1'b1, joy[11:8]};
                    default: PDRI = {PDRO[6:5], 1'b1, joy[3], (pad_mode == 2) ? 3'b011 : 3'b100};
                endcase
            end else begin
                PDRI = 7'h7C;
            end
        end
    end

    task automatic run_poll();
        logic [15:0] b0;
        logic [13:0] cur;
        r_log.delete();
        r_len.delete();
        r_ticks = 0; r_done = 0; r_saw60 = 0; r_early = 0; r_ce_at_done = 0;
        b0 = BUTTONS;
        r_log.push_back({DDR, PDRO});
        r_len.push_back(0);
        START = 1'b1;
        for (int i = 0; i < 10 && !CE; i++) @(negedge CLK);
        @(negedge CLK);
        START = 1'b0;
        for (int c = 0; c < 3000 && !r_done; c++) begin
            cur = {DDR, PDRO};
            if (cur != r_log[r_log.size()-1]) begin
                r_log.push_back(cur);
                r_len.push_back(0);
            end
            r_len[r_len.size()-1] = r_len[r_len.size()-1] + 1;
            if (DDR == 7'h60) r_saw60 = 1;
            if (CE) r_ticks++;
            if (DONE) begin
                r_done = 1; r_buttons = BUTTONS; r_present = PRESENT; r_ce_at_done = CE;
            end else begin
                if (BUTTONS !== b0) r_early = 1;
                @(negedge CLK);
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if ({BUSY, DONE, PRESENT} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got=%b want=000", {BUSY, DONE, PRESENT});
        end
        checks++;
        if (BUTTONS !== 16'hFFFF || DDR !== 7'h00 || PDRO !== 7'h7F) begin
            failures++; $display("FAIL reset_port got=%h/%h/%h want=ffff/00/7f", BUTTONS, DDR, PDRO);
        end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_present();
        logic [13:0] exp_log[6];
        exp_log = '{{7'h00, 7'h7F}, {7'h60, 7'h1F}, {7'h60, 7'h3F},
                    {7'h60, 7'h5F}, {7'h60, 7'h7F}, {7'h00, 7'h7F}};
        ce_div = 1; pad_mode = 0; joy = 16'h1234;
        run_poll();
        checks++;
        if (!r_done || r_ticks !== 41) begin
            failures++; $display("FAIL present_latency got=%0d done=%0d want=41", r_ticks, r_done);
        end
        checks++;
        if (r_present !== 1'b1 || r_buttons !== 16'h1237) begin
            failures++; $display("FAIL present_word got=%b/%h want=1/1237", r_present, r_buttons);
        end
        checks++;
        if (r_log.size() != 6) begin
            failures++; $display("FAIL drive_seq_len got=%0d want=6", r_log.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (r_log[i] !== exp_log[i]) begin
                    failures++; $display("FAIL drive_seq[%0d] got=%h want=%h", i, r_log[i], exp_log[i]);
                end
            end
            checks++;
            if (r_len[1] != 8 || r_len[2] != 8 || r_len[3] != 8 || r_len[4] != 8) begin
                failures++; $display("FAIL phase_len got=%0d,%0d,%0d,%0d want=8", r_len[1], r_len[2], r_len[3], r_len[4]);
            end
        end
        @(negedge CLK);
        checks++;
        if (DONE !== 1'b0 || BUSY !== 1'b0) begin
            failures++; $display("FAIL present_after got done=%b busy=%b want=0/0", DONE, BUSY);
        end
    endtask

    task automatic test_absent();
        ce_div = 1; pad_mode = 1;
        run_poll();
        checks++;
        if (!r_done || r_ticks !== 9) begin
            failures++; $display("FAIL absent_latency got=%0d done=%0d want=9", r_ticks, r_done);
        end
        checks++;
        if (r_present !== 1'b0 || r_buttons !== 16'hFFFF) begin
            failures++; $display("FAIL absent_word got=%b/%h want=0/ffff", r_present, r_buttons);
        end
        checks++;
        if (r_saw60) begin
            failures++; $display("FAIL absent_ph0_driven got=1 want=0");
        end
        pad_mode = 0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_bad_id();
        ce_div = 1; pad_mode = 0; joy = 16'h1234;
        run_poll();
        checks++;
        if (BUTTONS !== 16'h1237 || PRESENT !== 1'b1) begin
            failures++; $display("FAIL bad_id_setup got=%h/%b want=1237/1", BUTTONS, PRESENT);
        end
        @(negedge CLK);
        pad_mode = 2;
        run_poll();
        checks++;
        if (r_early) begin
            failures++; $display("FAIL bad_id_early_update got=1 want=0");
        end
        checks++;
        if (!r_done || r_present !== 1'b0 || r_buttons !== 16'hFFFF) begin
            failures++; $display("FAIL bad_id_word got=%b/%h done=%0d want=0/ffff", r_present, r_buttons, r_done);
        end
        pad_mode = 0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_slow_ce();
        ce_div = 3; pad_mode = 0; joy = 16'hA5F8;
        repeat (3) @(negedge CLK);
        run_poll();
        checks++;
        if (!r_done || r_ticks !== 41 || r_ce_at_done !== 1'b1) begin
            failures++; $display("FAIL slow_latency got=%0d ce=%b want=41/1", r_ticks, r_ce_at_done);
        end
        checks++;
        if (r_buttons !== 16'hA5FF || r_present !== 1'b1) begin
            failures++; $display("FAIL slow_word got=%h/%b want=a5ff/1", r_buttons, r_present);
        end
        checks++;
        if (r_len.size() < 5 || r_len[1] != 24 || r_len[2] != 24 || r_len[3] != 24 || r_len[4] != 24) begin
            failures++; $display("FAIL slow_phase_len entries=%0d want 4x24", r_len.size());
        end
        @(negedge CLK);
        checks++;
        if (DONE !== 1'b0) begin
            failures++; $display("FAIL slow_done_width got=%b want=0", DONE);
        end
        ce_div = 1;
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        int  dones = 0;
        bit  seen_ph1 = 0;
        bit  seen_ph2 = 0;
        ce_div = 1; pad_mode = 0; joy = 16'h1234;
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (DDR == 7'h60 && PDRO == 7'h3F && !seen_ph1) begin
                seen_ph1 = 1; START = 1'b1;
            end else begin
                START = 1'b0;
            end
            if (DONE) dones++;
            @(negedge CLK);
        end
        START = 1'b0;
        checks++;
        if (dones != 1 || !seen_ph1) begin
            failures++; $display("FAIL restart_ignored dones=%0d ph1=%0d want=1/1", dones, seen_ph1);
        end
        checks++;
        if (BUTTONS !== 16'h1237) begin
            failures++; $display("FAIL restart_word got=%h want=1237", BUTTONS);
        end
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        for (int c = 0; c < 100 && !seen_ph2; c++) begin
            if (DDR == 7'h60 && PDRO == 7'h5F) seen_ph2 = 1;
            else @(negedge CLK);
        end
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if (!seen_ph2 || DDR !== 7'h00 || PDRO !== 7'h7F || BUSY !== 1'b0 || BUTTONS !== 16'hFFFF) begin
            failures++; $display("FAIL midpoll_reset ph2=%0d got=%h/%h/%b/%h want=00/7f/0/ffff",
                                 seen_ph2, DDR, PDRO, BUSY, BUTTONS);
        end
        RST = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_present();
        test_absent();
        test_bad_id();
        test_slow_ce();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
